// File: rtl/regfile_param_sweep.sv
// MIPS32-style register file: two source read ports, a gated MAC read port and one write port,
// with a built-in clear sweep after reset or on clr_req. Define REGFILE_WR_BYPASS_EN for write-first reads.
module regfile_param_sweep #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              mac_en,
  input  logic [ADDR_W-1:0] mac_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] mac_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {SWEEP, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              run;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    case (state_q)
      SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = SWEEP;
        ptr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign run   = (state_q == RUN);
  assign ready = ready_q;

  // The sweep owns the write port; user writes are accepted only in RUN.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_addr;
    mem_wd = wr_data;
    if (!run) begin
      mem_we = 1'b1;
      mem_wa = ptr_q;
      mem_wd = '0;
    end else if (wr_en && !(ZERO_REG != 0 && wr_addr == '0)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              is_run,
    input logic              byp_we,
    input logic [ADDR_W-1:0] byp_addr,
    input logic [DATA_W-1:0] byp_data
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (BYPASS && byp_we && addr == byp_addr) v = byp_data;
    if (ZERO_REG != 0 && addr == '0) v = '0;
    if (!is_run) v = '0;
    return v;
  endfunction

  assign rs1_data = read_sel(rs1_addr, mem[rs1_addr], run, wr_en, wr_addr, wr_data);
  assign rs2_data = read_sel(rs2_addr, mem[rs2_addr], run, wr_en, wr_addr, wr_data);
  assign mac_data = mac_en ? read_sel(mac_addr, mem[mac_addr], run, wr_en, wr_addr, wr_data) : '0;

endmodule

// File: tb/tb_regfile_param_sweep.sv
// Self-checking bench for regfile_param_sweep: reset sweep, writes, bypass, MAC port,
// clear request and reset during a sweep. Expected values flow through a scoreboard queue.
module tb_regfile_param_sweep;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, mac_addr, wr_addr;
  logic        mac_en, wr_en, clr_req;
  logic [31:0] rs1_data, rs2_data, mac_data, wr_data;
  logic        ready;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  regfile_param_sweep #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .mac_en(mac_en), .mac_addr(mac_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .mac_data(mac_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clr_req = 1'b0; mac_en = 1'b0; mac_addr = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_reset();
    int cyc;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({31'd0, ready} !== exp_v) begin
      n_bad++; $display("FAIL reset_ready_low: got %0d want %0d", ready, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rs1_addr = 5'd3;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) break;
      if (cyc == 15) begin
        exp_q.push_back(32'd0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rs1_data !== exp_v) begin
          n_bad++; $display("FAIL reset_sweep_read: got %h want %h", rs1_data, exp_v);
        end
      end
    end
    exp_q.push_back(32'd32);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (cyc !== int'(exp_v)) begin
      n_bad++; $display("FAIL reset_sweep_len: got %0d cycles want %0d", cyc, exp_v);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs1_addr = i[4:0];
      rs2_addr = 5'(31 - i);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (rs1_data !== exp_v) begin
        n_bad++; $display("FAIL reset_zero_rs1[%0d]: got %h want %h", i, rs1_data, exp_v);
      end
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (rs2_data !== exp_v) begin
        n_bad++; $display("FAIL reset_zero_rs2[%0d]: got %h want %h", 31 - i, rs2_data, exp_v);
      end
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
    @(negedge clk);
    wr_en = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== exp_v) begin
      n_bad++; $display("FAIL write_r5: got %h want %h", rs1_data, exp_v);
    end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rs1_addr = 5'd0;
    exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== exp_v) begin
      n_bad++; $display("FAIL write_r0_same_cycle: got %h want %h", rs1_data, exp_v);
    end
    @(negedge clk);
    wr_en = 1'b0;
    exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== exp_v) begin
      n_bad++; $display("FAIL write_r0_after: got %h want %h", rs1_data, exp_v);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rs2_addr = 5'd7;
    mac_en = 1'b0; mac_addr = 5'd7;
`ifdef REGFILE_WR_BYPASS_EN
    exp_q.push_back(32'hA5A5A5A5);
`else
    exp_q.push_back(32'd0);
`endif
    exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rs2_data !== exp_v) begin
      n_bad++; $display("FAIL bypass_same_cycle: got %h want %h", rs2_data, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (mac_data !== exp_v) begin
      n_bad++; $display("FAIL bypass_mac_gated: got %h want %h", mac_data, exp_v);
    end
    @(negedge clk);
    wr_en = 1'b0;
    exp_q.push_back(32'hA5A5A5A5);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rs2_data !== exp_v) begin
      n_bad++; $display("FAIL bypass_next_cycle: got %h want %h", rs2_data, exp_v);
    end
  endtask

  task automatic test_mac();
    @(negedge clk);
    mac_en = 1'b0; mac_addr = 5'd5;
    exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (mac_data !== exp_v) begin
      n_bad++; $display("FAIL mac_disabled: got %h want %h", mac_data, exp_v);
    end
    @(negedge clk);
    mac_en = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd5;
    for (int k = 0; k < 3; k++) exp_q.push_back(32'hDEADBEEF);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (mac_data !== exp_v) begin
      n_bad++; $display("FAIL mac_enabled: got %h want %h", mac_data, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== exp_v) begin
      n_bad++; $display("FAIL mac_same_rs1: got %h want %h", rs1_data, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rs2_data !== exp_v) begin
      n_bad++; $display("FAIL mac_same_rs2: got %h want %h", rs2_data, exp_v);
    end
    @(negedge clk);
    mac_en = 1'b0;
  endtask

  task automatic test_clear();
    int cyc;
    logic [4:0] chk [3];
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; clr_req = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({31'd0, ready} !== exp_v) begin
      n_bad++; $display("FAIL clear_ready_drop: got %0d want %0d", ready, exp_v);
    end
    cyc = 1;
    while (cyc < 100) begin
      @(negedge clk);
      wr_en = 1'b0; clr_req = 1'b0;
      if (cyc == 10) begin
        rs1_addr = 5'd5;
        exp_q.push_back(32'd0);
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rs1_data !== exp_v) begin
          n_bad++; $display("FAIL clear_sweep_read: got %h want %h", rs1_data, exp_v);
        end
      end
      if (cyc == 20) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF; clr_req = 1'b1;
      end
      @(posedge clk); #1;
      if (ready) break;
      cyc++;
    end
    exp_q.push_back(32'd32);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (cyc !== int'(exp_v)) begin
      n_bad++; $display("FAIL clear_sweep_len: got %0d cycles want %0d", cyc, exp_v);
    end
    @(negedge clk);
    wr_en = 1'b0; clr_req = 1'b0;
    chk[0] = 5'd9; chk[1] = 5'd5; chk[2] = 5'd3;
    for (int i = 0; i < 3; i++) begin
      rs1_addr = chk[i];
      exp_q.push_back(32'd0);
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (rs1_data !== exp_v) begin
        n_bad++; $display("FAIL clear_entry_r%0d: got %h want %h", chk[i], rs1_data, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0BADF00D;
    @(negedge clk);
    wr_en = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({31'd0, ready} !== exp_v) begin
      n_bad++; $display("FAIL midreset_ready: got %0d want %0d", ready, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) break;
    end
    exp_q.push_back(32'd32);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (cyc !== int'(exp_v)) begin
      n_bad++; $display("FAIL midreset_sweep_len: got %0d cycles want %0d", cyc, exp_v);
    end
    @(negedge clk);
    rs1_addr = 5'd12;
    exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== exp_v) begin
      n_bad++; $display("FAIL midreset_r12: got %h want %h", rs1_data, exp_v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_write();
    test_bypass();
    test_mac();
    test_clear();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
